// File: rtl/fire_expand_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module   : fire_expand_ofm_writer
// Brief    : Captures one parallel OFM bank (one pixel, all channels) on a
//            sample strobe, then serialises it into the next layer's
//            feature-map RAM write port with channel-interleaved addressing.
//            Counts pixels per layer, pulses layer completion and flags
//            samples lost while the shadow buffer is still being drained.
// Revision : 1.0 - initial release
// ============================================================================
module fire_expand_ofm_writer #(
    parameter int                DSP_NO    = 64,
    parameter int                WIDTH     = 16,
    parameter int                PIXEL_NO  = 3025,
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1],
    input  logic              ofm_sample_i,
    input  logic              layer_start_i,
    input  logic              wr_ready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WIDTH-1:0]  wr_data_o,
    output logic              busy_o,
    output logic              layer_done_o,
    output logic              overrun_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CW = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int c_PW = $clog2(PIXEL_NO + 1);

    localparam logic [c_CW-1:0]   c_CH_LAST  = c_CW'(DSP_NO - 1);
    localparam logic [c_PW-1:0]   c_PIX_LAST = c_PW'(PIXEL_NO - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,   state_d;
    logic [c_CW-1:0]   chan_q,    chan_d;
    logic [c_PW-1:0]   pix_q,     pix_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              overrun_q, overrun_d;

    // Shadow copy of the bank; only read while streaming, so it needs no reset.
    logic [WIDTH-1:0]  buf_q [0:DSP_NO-1];

    logic xfer_w;     // a word leaves the buffer this cycle
    logic last_w;     // that word is the final channel of the pixel
    logic wrap_w;     // that final channel also completes the layer
    logic accept_w;   // the strobed sample is captured this cycle
    logic drop_w;     // the strobed sample is lost this cycle

    // Handshake and sample-acceptance decode shared by FSM and counters
    always_comb begin
        xfer_w   = (state_q == c_STREAM) && wr_ready_i;
        last_w   = xfer_w && (chan_q == c_CH_LAST);
        wrap_w   = last_w && (pix_q == c_PIX_LAST);
        // layer_start swallows a coincident sample without flagging it
        accept_w = ofm_sample_i && !layer_start_i &&
                   ((state_q == c_IDLE) || last_w);
        drop_w   = ofm_sample_i && !layer_start_i && !accept_w;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; layer_start overrides every state
    always_comb begin
        state_d = state_q;
        if (layer_start_i) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (accept_w) begin
                        state_d = c_STREAM;
                    end
                end
                c_STREAM: begin
                    if (last_w) begin
                        if (wrap_w) begin
                            state_d = c_DONE;
                        end else if (accept_w) begin
                            // back-to-back pixel: keep streaming, no bubble
                            state_d = c_STREAM;
                        end else begin
                            state_d = c_IDLE;
                        end
                    end
                end
                c_DONE: begin
                    state_d = c_IDLE;
                end
                default: begin
                    state_d = c_IDLE;
                end
            endcase
        end
    end

    // FSM outputs and the word mux; data is forced to zero when not writing
    always_comb begin
        wr_en_o      = (state_q == c_STREAM);
        busy_o       = (state_q == c_STREAM);
        layer_done_o = (state_q == c_DONE);
        wr_addr_o    = addr_q;
        overrun_o    = overrun_q;
        wr_data_o    = (state_q == c_STREAM) ? buf_q[chan_q] : '0;
    end

    // Next values of channel, pixel and address counters and the overrun flag
    always_comb begin
        chan_d    = chan_q;
        pix_d     = pix_q;
        addr_d    = addr_q;
        overrun_d = overrun_q;
        if (layer_start_i) begin
            chan_d    = '0;
            pix_d     = '0;
            addr_d    = BASE_ADDR;
            overrun_d = 1'b0;
        end else begin
            if (xfer_w) begin
                // running address, wraps naturally at 2^ADDR_W
                addr_d = addr_q + c_ADDR_ONE;
                chan_d = last_w ? '0 : chan_q + c_CW'(1);
            end
            if (last_w) begin
                pix_d = pix_q + c_PW'(1);
            end
            if (state_q == c_DONE) begin
                pix_d  = '0;
                addr_d = BASE_ADDR;
            end
            if (drop_w) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            chan_q    <= '0;
            pix_q     <= '0;
            addr_q    <= BASE_ADDR;
            overrun_q <= 1'b0;
        end else begin
            chan_q    <= chan_d;
            pix_q     <= pix_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
        end
    end

    // Shadow buffer capture, one register word per channel
    for (genvar gi = 0; gi < DSP_NO; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (accept_w) begin
                buf_q[gi] <= ofm_i[gi];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fire_expand_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_expand_ofm_writer
// Brief    : Scoreboard bench for fire_expand_ofm_writer. A queue-based
//            reference model predicts the words each accepted pixel will
//            write; a monitor pops and compares on every RAM transfer and
//            checks the control outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire_expand_ofm_writer;

    localparam int DSP_NO   = 64;
    localparam int WIDTH    = 16;
    localparam int PIXEL_NO = 2;
    localparam int ADDR_W   = 18;
    localparam int BASE     = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
    logic              ofm_sample = 1'b0;
    logic              layer_start = 1'b0;
    logic              wr_ready = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              busy;
    logic              layer_done;
    logic              overrun;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Reference model state
    exp_t exp_q[$];
    int   m_left   = 0;  // words of the current pixel still to be written
    int   m_pix    = 0;  // pixels fully written in this layer
    int   m_issued = 0;  // pixels accepted in this layer
    bit   m_done   = 1'b0;
    bit   m_over   = 1'b0;

    fire_expand_ofm_writer #(
        .DSP_NO   (DSP_NO),
        .WIDTH    (WIDTH),
        .PIXEL_NO (PIXEL_NO),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(ADDR_W'(BASE))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ofm_i        (ofm),
        .ofm_sample_i (ofm_sample),
        .layer_start_i(layer_start),
        .wr_ready_i   (wr_ready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .layer_done_o (layer_done),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, from the behavioural rules
    task automatic model(input bit s, input bit ls, input bit rdy, input bit rv);
        bit idle, xfer, last, acc, nd;
        if (!rv || ls) begin
            m_left = 0; m_pix = 0; m_issued = 0; m_done = 1'b0; m_over = 1'b0;
            exp_q.delete();
            return;
        end
        idle = (m_left == 0) && !m_done;
        xfer = (m_left > 0) && rdy;
        last = xfer && (m_left == 1);
        nd   = 1'b0;
        if (xfer) m_left--;
        if (last) begin
            m_pix++;
            if (m_pix == PIXEL_NO) nd = 1'b1;
        end
        acc = s && (idle || last);
        if (acc && !nd) begin
            for (int k = 0; k < DSP_NO; k++) begin
                exp_t e;
                e.a = ADDR_W'(BASE + m_issued * DSP_NO + k);
                e.d = ofm[k];
                exp_q.push_back(e);
            end
            m_issued++;
            m_left = DSP_NO;
        end else if (s && !acc) begin
            m_over = 1'b1;
        end
        if (m_done) begin
            m_pix = 0;
            m_issued = 0;
        end
        m_done = nd;
    endtask

    // One cycle: drive on the falling edge, advance the model on the rising edge
    task automatic step(input bit s, input bit ls, input bit rdy, input bit rv,
                        input int fill, input logic [WIDTH-1:0] base);
        @(negedge clk);
        if (fill == 1) begin
            for (int k = 0; k < DSP_NO; k++) ofm[k] = base + WIDTH'(k);
        end else if (fill == 2) begin
            for (int k = 0; k < DSP_NO; k++) ofm[k] = WIDTH'($urandom);
        end
        ofm_sample  = s;
        layer_start = ls;
        wr_ready    = rdy;
        rst         = rv;
        @(posedge clk);
        model(s, ls, rdy, rv);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1, 0, '0);
    endtask

    // Monitor: control outputs every cycle, scoreboard pop on each transfer
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                int ea;
                ea = (BASE + m_pix * DSP_NO + ((m_left > 0) ? DSP_NO - m_left : 0)) % (1 << ADDR_W);
                chk("wr_en", 32'(wr_en), 32'(m_left > 0));
                chk("busy", 32'(busy), 32'(m_left > 0));
                chk("layer_done", 32'(layer_done), 32'(m_done));
                chk("overrun", 32'(overrun), 32'(m_over));
                chk("wr_addr", 32'(wr_addr), 32'(ea));
                if (!wr_en) chk("wr_data_idle", 32'(wr_data), 32'd0);
                if (wr_en && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write actual_addr=%h actual_data=%h required=none at %0t",
                                 wr_addr, wr_data, $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("xfer_addr", 32'(wr_addr), 32'(e.a));
                        chk("xfer_data", 32'(wr_data), 32'(e.d));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        for (int k = 0; k < DSP_NO; k++) ofm[k] = '0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, '0);
        mon_en = 1'b1;
        idle_n(2);

        // Single pixel, ready always high
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 1, 16'h0100);
        idle_n(70);

        // Single pixel, ready alternating
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 1, 16'h0100);
        for (int i = 1; i <= 140; i++) step(0, 0, (i % 2) == 1, 1, 0, '0);

        // Back-to-back pixels: second strobe on the 64th transfer (fills layer)
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 1, 16'h0200);
        idle_n(63);
        step(1, 0, 1, 1, 1, 16'h0300);
        idle_n(70);

        // Overrun: second strobe mid-burst, then cleared by layer_start
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 1, 16'h0400);
        idle_n(9);
        step(1, 0, 1, 1, 1, 16'h0500);
        idle_n(70);
        step(0, 1, 1, 1, 0, '0);
        idle_n(2);

        // Layer completion, then a further pixel restarts at the base address
        step(1, 0, 1, 1, 1, 16'h0600);
        idle_n(63);
        step(1, 0, 1, 1, 1, 16'h0700);
        idle_n(70);
        step(1, 0, 1, 1, 1, 16'h0800);
        idle_n(70);

        // Reset at transfer 20, then a new pixel from the base address
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 1, 16'h0900);
        idle_n(19);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        idle_n(2);
        step(1, 0, 1, 1, 1, 16'h0A00);
        idle_n(70);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, ls, rdy;
            s   = ($urandom_range(0, 15) == 0);
            ls  = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(s, ls, rdy, 1, s ? 2 : 0, '0);
        end
        idle_n(80);

        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fire_expand_ofm_writer.md
Name: fire_expand_ofm_writer

Overview:
Consumer end of the expand-layer output interface. On each `fire*_expand_1_sample` pulse it captures the DSP_NO-wide parallel OFM bank (one pixel, all channels) into a shadow buffer. It then serialises the bank, one word per accepted cycle, into the next layer's feature-map RAM write port with channel-interleaved addressing. It counts pixels per layer, signals layer completion, and flags samples lost while busy.

Parameters:
DSP_NO, 64, number of parallel OFM words (channels) per sample
WIDTH, 16, data word width
PIXEL_NO, 3025, pixels (samples) per layer; 55x55
ADDR_W, 18, write address width; must hold PIXEL_NO*DSP_NO
BASE_ADDR, 0, first RAM address of the layer

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ofm  in  WIDTH x [0:DSP_NO-1]  parallel OFM bank from the expand block
ofm_sample  in  1  one-cycle strobe: ofm is valid this cycle
layer_start  in  1  one-cycle strobe: begin a new layer
wr_ready  in  1  RAM port can accept a word this cycle
wr_en  out  1  write valid
wr_addr  out  ADDR_W  write address
wr_data  out  WIDTH  write data
busy  out  1  buffer holds untransferred words
layer_done  out  1  one-cycle pulse after the last word of the layer
overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (rst==0 at posedge): state IDLE. wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, layer_done=0, overrun=0, pixel counter=0, channel counter=0. Shadow buffer contents are don't-care. Reset mid-stream abandons the remaining words with no further writes.
- States: IDLE, STREAM, DONE.
- Transfer: occurs on a cycle with wr_en && wr_ready. wr_en, wr_addr and wr_data hold stable until the word is transferred. wr_en=0 never advances the counters.
- Sample acceptance: ofm_sample is accepted in IDLE, or in STREAM when the cycle performs the transfer of channel DSP_NO-1. Accepting a sample copies all DSP_NO words into the buffer at that posedge.
- Sample loss: ofm_sample in any other case (STREAM not on its last transfer, or DONE) drops the sample and sets overrun=1. overrun stays set until reset or layer_start.
- IDLE -> STREAM on an accepted sample. From the next cycle: wr_en=1, wr_data=buf[0], busy=1. Latency from sample strobe to first wr_en is 1 cycle.
- STREAM, transfer of channel c<DSP_NO-1: the next cycle presents buf[c+1] at wr_addr+1.
- STREAM, transfer of channel DSP_NO-1: the pixel counter increments.
  - If the pixel counter reaches PIXEL_NO: go to DONE; wr_en=0, busy=0.
  - Else, if a sample is accepted in the same cycle: stay in STREAM with channel 0 of the new buffer presented the next cycle, with no bubble.
  - Else: go to IDLE; wr_en=0, busy=0.
- DONE lasts exactly 1 cycle. layer_done=1 during it. Then IDLE with the pixel counter=0 and wr_addr=BASE_ADDR.
- Address: wr_addr = BASE_ADDR + pixel*DSP_NO + channel. It is implemented as a running counter incremented per transfer and wraps modulo 2^ADDR_W.
- layer_start: highest priority after reset, in any state. Next cycle: IDLE, wr_en=0, busy=0, counters and wr_addr reset to BASE_ADDR, overrun=0.
- layer_start coincident with ofm_sample: layer_start wins, the sample is dropped, and overrun is not set.
- Any in-flight word at layer_start is abandoned.
- wr_data is a mux of the buffer by the channel counter, registered or combinational. Either way it must be valid in the same cycle as wr_en.

Test Plan:
- Reset, then layer_start. Apply ofm[i]=16'h0100+i with ofm_sample at cycle T, wr_ready=1 -> wr_en high cycles T+1..T+64, wr_addr 0..63, wr_data 16'h0100..16'h013F. busy falls at T+65 and overrun stays 0.
- Same as above with wr_ready toggling 1,0,1,0 -> exactly 64 transfers, with addr/data held across each wr_ready=0 cycle. Completion at T+128.
- Second sample strobed on the cycle of the first sample's 64th transfer -> 128 contiguous transfers, addresses 0..127, no wr_en gap, overrun=0.
- Second sample strobed at T+10 while streaming -> overrun=1. The first 64 words are unaffected and no second burst occurs. A following layer_start clears overrun.
- PIXEL_NO=2 override, two samples -> 128 writes (addresses 0..127), then layer_done high for exactly 1 cycle. A third sample then writes starting again at BASE_ADDR.
- rst=0 asserted at transfer 20 of a burst -> wr_en=0 from the next cycle and all outputs at reset values. After release, a new sample writes starting at BASE_ADDR.
